// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the
// pipeline writeback stage (port A, no backpressure) and the mult/div
// result path (port B, valid/ready, buffered in a 2-entry FIFO).
// A starvation counter raises stall_pipe for one cycle so that buffered
// B results can drain. All write-port outputs are registered (latency 1).
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              stall_pipe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        fifo_count,
  output logic              proto_err
);

  // Starve counter is wide enough for the full legal limit range (1..15).
  localparam int                CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  // FIFO storage: slot0 is always the head; valid entries are fifo_count.
  entry_t           slot0, slot1;
  entry_t           slot0_next, slot1_next;
  entry_t           b_entry, wr_sel;
  logic [CNT_W-1:0] starve, starve_next, starve_inc;
  logic [1:0]       count_next, kept;
  logic             grant_a, pop, push, keep0, keep1;
  logic             wr_en_next, stall_next, proto_err_next;

  // B may push only when a slot is free and the block is out of reset.
  assign b_ready = ctrl_reset && (fifo_count != 2'd2);
  assign b_entry = '{rd: b_reg, data: b_data};

  // Grant, WAW kill, FIFO compaction/push and starvation bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    grant_a        = a_valid && (a_reg != '0);
    pop            = !grant_a && (fifo_count != 2'd0);
    // A granted write to R kills older FIFO entries targeting R; a pop
    // removes only the head. The two never happen on the same edge.
    keep0          = (fifo_count != 2'd0) && !pop && !(grant_a && (slot0.rd == a_reg));
    keep1          = (fifo_count == 2'd2) && !(grant_a && (slot1.rd == a_reg));
    push           = b_valid && b_ready && (b_reg != '0);
    kept           = 2'(keep0) + 2'(keep1);
    count_next     = kept + 2'(push);

    // Compact survivors toward the head, then append the new entry after them.
    slot0_next     = keep0 ? slot0 : slot1;
    slot1_next     = slot1;
    if (push) begin
      if (kept == 2'd0) slot0_next = b_entry;
      else              slot1_next = b_entry;
    end

    wr_en_next     = grant_a || pop;
    wr_sel         = grant_a ? '{rd: a_reg, data: a_data} : slot0;
    proto_err_next = proto_err || (a_valid && stall_pipe);

    // Count cycles where buffered data waits; a stall is never issued
    // directly after another one, the count saturates until it can fire.
    starve_inc     = (starve >= LIMIT) ? LIMIT : starve + 1'b1;
    starve_next    = starve;
    stall_next     = 1'b0;
    if (pop || (count_next == 2'd0)) begin
      starve_next = '0;
    end else if (fifo_count != 2'd0) begin
      if ((starve_inc == LIMIT) && !stall_pipe) begin
        stall_next  = 1'b1;
        starve_next = '0;
      end else begin
        starve_next = starve_inc;
      end
    end
  end

  // Control state and registered write-port outputs, synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!ctrl_reset) begin
      fifo_count <= 2'd0;
      starve     <= '0;
      stall_pipe <= 1'b0;
      proto_err  <= 1'b0;
      wr_en      <= 1'b0;
      wr_reg     <= '0;
      wr_data    <= '0;
    end else begin
      fifo_count <= count_next;
      starve     <= starve_next;
      stall_pipe <= stall_next;
      proto_err  <= proto_err_next;
      wr_en      <= wr_en_next;
      if (wr_en_next) begin
        wr_reg  <= wr_sel.rd;
        wr_data <= wr_sel.data;
      end
    end
  end

  // FIFO payload storage.
  always_ff @(posedge clock) begin
    // NOTE: payload slots are not reset; fifo_count alone marks which contents are meaningful.
    slot0 <= slot0_next;
    slot1 <= slot1_next;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: a directed vector table with hand-derived
// expectations, a sustained-violation stall sequence, and randomized traffic
// compared against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LIMIT  = 4;

  logic              clock = 1'b0;
  logic              ctrl_reset, a_valid, b_valid;
  logic [ADDR_W-1:0] a_reg, b_reg;
  logic [DATA_W-1:0] a_data, b_data;
  logic              b_ready, stall_pipe, wr_en, proto_err;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        fifo_count;

  int checks   = 0;
  int failures = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .stall_pipe(stall_pipe), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .fifo_count(fifo_count), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              mq[$];
  logic              m_wen = 0, m_stall = 0, m_err = 0;
  logic [ADDR_W-1:0] m_reg = 0;
  logic [DATA_W-1:0] m_data = 0;
  int                m_starve = 0;

  task automatic model_step(input logic rst, input logic av, input logic [ADDR_W-1:0] ar,
                            input logic [DATA_W-1:0] ad, input logic bv,
                            input logic [ADDR_W-1:0] br, input logic [DATA_W-1:0] bd);
    ent_t keep[$];
    bit   had, popped, ready, new_stall;
    if (!rst) begin
      mq.delete();
      m_wen = 0; m_reg = 0; m_data = 0; m_stall = 0; m_err = 0; m_starve = 0;
      return;
    end
    ready  = (mq.size() < 2);
    had    = (mq.size() != 0);
    popped = 0;
    if (av && m_stall) m_err = 1;
    if (av && ar != 0) begin
      m_wen = 1; m_reg = ar; m_data = ad;
      foreach (mq[i]) if (mq[i].r != ar) keep.push_back(mq[i]);
      mq = keep;
    end else if (had) begin
      m_wen = 1; m_reg = mq[0].r; m_data = mq[0].d;
      void'(mq.pop_front());
      popped = 1;
    end else begin
      m_wen = 0;
    end
    if (bv && ready && br != 0) mq.push_back('{br, bd});
    new_stall = 0;
    if (popped || mq.size() == 0) begin
      m_starve = 0;
    end else if (had) begin
      m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      if (m_starve == LIMIT && !m_stall) begin
        new_stall = 1;
        m_starve  = 0;
      end
    end
    m_stall = new_stall;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic av, input logic [ADDR_W-1:0] ar,
                       input logic [DATA_W-1:0] ad, input logic bv,
                       input logic [ADDR_W-1:0] br, input logic [DATA_W-1:0] bd);
    ctrl_reset = rst; a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
  endtask

  // One cycle compared against the model: b_ready before the edge, all
  // registered outputs 1 time unit after it.
  task automatic model_cycle(input string tag, input logic rst, input logic av,
                             input logic [ADDR_W-1:0] ar, input logic [DATA_W-1:0] ad,
                             input logic bv, input logic [ADDR_W-1:0] br,
                             input logic [DATA_W-1:0] bd);
    logic exp_ready;
    drive(rst, av, ar, ad, bv, br, bd);
    #1;
    exp_ready = rst && (mq.size() < 2);
    check({tag, " b_ready"}, 32'(b_ready), 32'(exp_ready));
    model_step(rst, av, ar, ad, bv, br, bd);
    @(posedge clock);
    #1;
    check({tag, " wr_en"},      32'(wr_en),      32'(m_wen));
    check({tag, " wr_reg"},     32'(wr_reg),     32'(m_reg));
    check({tag, " wr_data"},    wr_data,         m_data);
    check({tag, " fifo_count"}, 32'(fifo_count), 32'(mq.size()));
    check({tag, " stall_pipe"}, 32'(stall_pipe), 32'(m_stall));
    check({tag, " proto_err"},  32'(proto_err),  32'(m_err));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic              rst, av;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] ad;
    logic              bv;
    logic [ADDR_W-1:0] br;
    logic [DATA_W-1:0] bd;
    logic              e_ready, e_wen;
    logic [ADDR_W-1:0] e_reg;
    logic [DATA_W-1:0] e_data;
    logic [1:0]        e_cnt;
    logic              e_stall, e_err;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic av, input logic [ADDR_W-1:0] ar,
                             input logic [DATA_W-1:0] ad, input logic bv,
                             input logic [ADDR_W-1:0] br, input logic [DATA_W-1:0] bd,
                             input logic e_ready, input logic e_wen,
                             input logic [ADDR_W-1:0] e_reg, input logic [DATA_W-1:0] e_data,
                             input logic [1:0] e_cnt, input logic e_stall, input logic e_err);
    vec_t x;
    x.rst = rst; x.av = av; x.ar = ar; x.ad = ad; x.bv = bv; x.br = br; x.bd = bd;
    x.e_ready = e_ready; x.e_wen = e_wen; x.e_reg = e_reg; x.e_data = e_data;
    x.e_cnt = e_cnt; x.e_stall = e_stall; x.e_err = e_err;
    return x;
  endfunction

  vec_t vecs[$];
  logic prev_stall;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);

    //                 rst av ar  ad        bv br  bd           rdy wen reg data          cnt stl err
    // reset held two cycles with b_valid=1
    vecs.push_back(v(0, 0, 0,  0,        1, 5,  32'h1,        0,  0,  0,  32'h0,        0,  0,  0));
    vecs.push_back(v(0, 0, 0,  0,        1, 5,  32'h1,        0,  0,  0,  32'h0,        0,  0,  0));
    // idle pipeline: B push r5, written one edge later
    vecs.push_back(v(1, 0, 0,  0,        1, 5,  32'hDEADBEEF, 1,  0,  0,  32'h0,        1,  0,  0));
    vecs.push_back(v(1, 0, 0,  0,        0, 0,  0,            1,  1,  5,  32'hDEADBEEF, 0,  0,  0));
    vecs.push_back(v(1, 0, 0,  0,        0, 0,  0,            1,  0,  5,  32'hDEADBEEF, 0,  0,  0));
    // fill/full under continuous A traffic on r3, starvation stall, drain
    vecs.push_back(v(1, 1, 3,  32'hA5,   1, 7,  32'h77,       1,  1,  3,  32'hA5,       1,  0,  0));
    vecs.push_back(v(1, 1, 3,  32'hA6,   1, 8,  32'h88,       1,  1,  3,  32'hA6,       2,  0,  0));
    vecs.push_back(v(1, 1, 3,  32'hA7,   1, 9,  32'h99,       0,  1,  3,  32'hA7,       2,  0,  0));
    vecs.push_back(v(1, 1, 3,  32'hA8,   0, 0,  0,            0,  1,  3,  32'hA8,       2,  0,  0));
    vecs.push_back(v(1, 1, 3,  32'hA9,   0, 0,  0,            0,  1,  3,  32'hA9,       2,  1,  0));
    vecs.push_back(v(1, 0, 0,  0,        0, 0,  0,            0,  1,  7,  32'h77,       1,  0,  0));
    vecs.push_back(v(1, 0, 0,  0,        0, 0,  0,            1,  1,  8,  32'h88,       0,  0,  0));
    vecs.push_back(v(1, 0, 0,  0,        0, 0,  0,            1,  0,  8,  32'h88,       0,  0,  0));
    // WAW kill: FIFO {r9,0x11},{r4,0x22}; A writes r9=0x33
    vecs.push_back(v(1, 1, 3,  32'hB3,   1, 9,  32'h11,       1,  1,  3,  32'hB3,       1,  0,  0));
    vecs.push_back(v(1, 1, 3,  32'hB4,   1, 4,  32'h22,       1,  1,  3,  32'hB4,       2,  0,  0));
    vecs.push_back(v(1, 1, 9,  32'h33,   0, 0,  0,            0,  1,  9,  32'h33,       1,  0,  0));
    vecs.push_back(v(1, 0, 0,  0,        0, 0,  0,            1,  1,  4,  32'h22,       0,  0,  0));
    vecs.push_back(v(1, 0, 0,  0,        0, 0,  0,            1,  0,  4,  32'h22,       0,  0,  0));
    // r0 handling
    vecs.push_back(v(1, 0, 0,  0,        1, 0,  32'h55,       1,  0,  4,  32'h22,       0,  0,  0));
    vecs.push_back(v(1, 0, 0,  0,        0, 0,  0,            1,  0,  4,  32'h22,       0,  0,  0));
    vecs.push_back(v(1, 0, 0,  0,        1, 6,  32'h66,       1,  0,  4,  32'h22,       1,  0,  0));
    vecs.push_back(v(1, 1, 0,  32'hEE,   0, 0,  0,            1,  1,  6,  32'h66,       0,  0,  0));
    vecs.push_back(v(1, 0, 0,  0,        0, 0,  0,            1,  0,  6,  32'h66,       0,  0,  0));
    // protocol violation during stall, then mid-op reset with two entries buffered
    vecs.push_back(v(1, 1, 3,  32'hC3,   1, 10, 32'hAA,       1,  1,  3,  32'hC3,       1,  0,  0));
    vecs.push_back(v(1, 1, 3,  32'hC4,   1, 11, 32'hBB,       1,  1,  3,  32'hC4,       2,  0,  0));
    vecs.push_back(v(1, 1, 3,  32'hC5,   0, 0,  0,            0,  1,  3,  32'hC5,       2,  0,  0));
    vecs.push_back(v(1, 1, 3,  32'hC6,   0, 0,  0,            0,  1,  3,  32'hC6,       2,  0,  0));
    vecs.push_back(v(1, 1, 3,  32'hC7,   0, 0,  0,            0,  1,  3,  32'hC7,       2,  1,  0));
    vecs.push_back(v(1, 1, 3,  32'hC8,   0, 0,  0,            0,  1,  3,  32'hC8,       2,  0,  1));
    vecs.push_back(v(1, 1, 3,  32'hC9,   0, 0,  0,            0,  1,  3,  32'hC9,       2,  0,  1));
    vecs.push_back(v(0, 0, 0,  0,        1, 12, 32'hCC,       0,  0,  0,  32'h0,        0,  0,  0));
    vecs.push_back(v(1, 0, 0,  0,        0, 0,  0,            1,  0,  0,  32'h0,        0,  0,  0));

    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd);
      #1;
      check($sformatf("row%0d b_ready", i), 32'(b_ready), 32'(vecs[i].e_ready));
      // Keep the model in step so the later phases start from a known state.
      model_step(vecs[i].rst, vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].bv, vecs[i].br, vecs[i].bd);
      @(posedge clock);
      #1;
      check($sformatf("row%0d wr_en", i),      32'(wr_en),      32'(vecs[i].e_wen));
      check($sformatf("row%0d wr_reg", i),     32'(wr_reg),     32'(vecs[i].e_reg));
      check($sformatf("row%0d wr_data", i),    wr_data,         vecs[i].e_data);
      check($sformatf("row%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      check($sformatf("row%0d stall_pipe", i), 32'(stall_pipe), 32'(vecs[i].e_stall));
      check($sformatf("row%0d proto_err", i),  32'(proto_err),  32'(vecs[i].e_err));
    end

    // Sustained protocol violation: A never yields, stall must not repeat back to back.
    model_cycle("seq fill0", 1, 1, 3, 32'hD0, 1, 13, 32'h1313);
    model_cycle("seq fill1", 1, 1, 3, 32'hD1, 1, 14, 32'h1414);
    prev_stall = stall_pipe;
    for (int k = 0; k < 16; k++) begin
      model_cycle($sformatf("seq hold%0d", k), 1, 1, 3, 32'hE0 + 32'(k), 0, 0, 0);
      check($sformatf("seq hold%0d stall_back_to_back", k), 32'(prev_stall && stall_pipe), 32'h0);
      prev_stall = stall_pipe;
    end
    model_cycle("seq drain0", 1, 0, 0, 0, 0, 0, 0);
    model_cycle("seq drain1", 1, 0, 0, 0, 0, 0, 0);
    model_cycle("seq reset", 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model; small register sets
    // make kills, r0 cases and full-FIFO backpressure frequent.
    for (int n = 0; n < 400; n++) begin
      model_cycle($sformatf("rnd%0d", n),
                  ($urandom_range(0, 39) != 0),
                  ($urandom_range(0, 9) < 6),
                  ADDR_W'($urandom_range(0, 3)),
                  $urandom(),
                  ($urandom_range(0, 1) == 1),
                  ADDR_W'($urandom_range(0, 3)),
                  $urandom());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
